mlp_infer_engine: RTL and testbench
===================================

# mlp_infer_engine

Parametrised two-layer MLP inference engine: for each of M input samples it computes H hidden neurons (bias plus N-term dot product, then a selectable activation) and a single output neuron (bias plus H-term dot product), writing one result per sample. It sits behind the AXI-Stream coprocessor wrapper, replacing the fixed 64×7×2 input-hidden datapath. It reads the input, hidden-weight and output-weight RAMs and writes the result RAM. It adds signed fixed-point arithmetic, saturation, runtime activation select, busy and saturation status, and full two-layer sequencing.

## Interface
- WIDTH, 8: data bits; signed two's complement on every RAM port
- FRAC_BITS, 6: fractional bits of the fixed-point format (Q(WIDTH-FRAC_BITS).FRAC_BITS)
- M, 64: samples (rows of A)
- N, 7: features per sample
- H, 2: hidden neurons
- A_depth_bits, 9 / B_depth_bits, 4 / C_depth_bits, 2 / RES_depth_bits, 6: RAM address widths
- clk  in  1  single clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- Start  in  1  one-cycle start request
- act_sel  in  1  hidden activation: 0 identity, 1 ReLU; sampled with Start
- Busy  out  1  high from accepted Start until Done
- Done  out  1  one-cycle completion pulse
- sat_flag  out  1  sticky: any result saturated in current/last run
- A_read_en, A_read_address  out  1, A_depth_bits  input RAM; A[r][k] at r*N+k
- A_read_data_out  in  WIDTH
- B_read_en, B_read_address  out  1, B_depth_bits  hidden weights; row 0 = biases; B[i][j] at i*H+j, i in 0..N
- B_read_data_out  in  WIDTH
- C_read_en, C_read_address  out  1, C_depth_bits  output weights; C[0] bias, C[j+1] weight of hidden j
- C_read_data_out  in  WIDTH
- RES_write_en, RES_write_address, RES_write_data_in  out  1, RES_depth_bits, WIDTH  result RAM; RES[r] at r

## Operation
- All RAMs synchronous read, 1-cycle latency: data for an address presented with read_en in cycle t is valid in cycle t+1.
- FSM: IDLE → H_BIAS → H_MAC (N cycles) → H_DRAIN → H_ACT → (next j: H_BIAS | j=H-1: O_BIAS) → O_MAC (H cycles) → O_DRAIN → O_WRITE → (next r: H_BIAS | r=M-1: DONE) → IDLE.
- Accumulator: signed, 2*WIDTH+clog2(max(N,H)+1) bits. Bias term enters as bias<<<FRAC_BITS; each product is a full 2*WIDTH signed product.
- Neuron result = acc>>>FRAC_BITS (arithmetic, truncate toward −∞), saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; any clamp sets sat_flag.
- Hidden: ReLU (act_sel=1) replaces negative saturated value with 0; results held in an internal H-entry register file. Output neuron: identity, saturated.
- act_sel latched at Start; changes while Busy ignored.
- Start while Busy ignored; Start in the same cycle as Done is ignored (accepted only in IDLE).
- sat_flag cleared on accepted Start; held after Done until next Start.
- read_en deasserted in every cycle with no read issued; RAM addresses hold their last value when idle.

## Timing
- Reset (async assert, sync release): state IDLE; Busy, Done, sat_flag, all read_en, RES_write_en = 0; all addresses and RES_write_data_in = 0; accumulator and hidden file cleared.
- Start sampled at edge E0: Busy=1 and first B_read_en (bias) in cycle 1.
- Per hidden neuron N+3 cycles; output neuron H+3 cycles; per sample H*(N+3)+H+3 cycles (defaults: 25).
- RES_write_en for the last sample in cycle M*(H*(N+3)+H+3) (defaults: 1600); Done=1, Busy=0 in the next cycle for exactly one cycle.
- Reset mid-run: immediate abort, no further RAM accesses or writes, no Done.

## Test plan
- Defaults to M=2,N=2,H=2: A all 0x20, B biases 0, B weights 0x20, C bias 0, C weights 0x40, act_sel=0 → RES[0]=RES[1]=0x40, sat_flag=0, Done pulse in cycle 2*(2*5+5)+1=31.
- Same, B weights 0xE0, C bias 0x10: act_sel=0 → RES=0xD0 (−48); act_sel=1 → RES=0x10.
- A all 0x40, B weights 0x40, biases 0 → hidden 128 clamps to 0x7F, sat_flag=1 after Done; next Start clears it.
- Start pulsed at cycles 5 and 20 of a run and coincident with Done → ignored; exactly one Done, RES writes only to addresses 0..M−1 in order.
- aresetn low at cycle 12 → all outputs zero immediately, no RES writes afterwards; fresh Start gives the correct full result.
- Defaults (64×7×2), random data vs. reference model with identical truncation and saturation → all 64 RES match, Done in cycle 1601.

Source files
------------

// File: rtl/mlp_infer_engine.sv
// mlp_infer_engine: two-layer fixed-point MLP (N inputs -> H hidden -> 1 output)
// run over M samples read from A/B/C RAMs, one saturated result per sample to RES.
// Ports: clk, aresetn | Start, act_sel -> Busy, Done, sat_flag
//        A/B/C_read_en/_address -> RAM, A/B/C_read_data_out <- RAM (1-cycle latency)
//        RES_write_en/_address/_data_in -> result RAM
module mlp_infer_engine #(
    parameter int WIDTH          = 8,
    parameter int FRAC_BITS      = 6,
    parameter int M              = 64,
    parameter int N              = 7,
    parameter int H              = 2,
    parameter int A_depth_bits   = 9,
    parameter int B_depth_bits   = 4,
    parameter int C_depth_bits   = 2,
    parameter int RES_depth_bits = 6
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      Start,
    input  logic                      act_sel,
    output logic                      Busy,
    output logic                      Done,
    output logic                      sat_flag,
    output logic                      A_read_en,
    output logic [A_depth_bits-1:0]   A_read_address,
    input  logic [WIDTH-1:0]          A_read_data_out,
    output logic                      B_read_en,
    output logic [B_depth_bits-1:0]   B_read_address,
    input  logic [WIDTH-1:0]          B_read_data_out,
    output logic                      C_read_en,
    output logic [C_depth_bits-1:0]   C_read_address,
    input  logic [WIDTH-1:0]          C_read_data_out,
    output logic                      RES_write_en,
    output logic [RES_depth_bits-1:0] RES_write_address,
    output logic [WIDTH-1:0]          RES_write_data_in
);

    localparam int MX = (N > H) ? N : H;
    localparam int KW = $clog2(MX + 1);
    localparam int AW = 2 * WIDTH + KW;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int JW = (H > 1) ? $clog2(H) : 1;

    localparam logic signed [AW-1:0] MAXV =
        {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_H_BIAS, S_H_MAC, S_H_DRAIN, S_H_ACT,
        S_O_BIAS, S_O_MAC, S_O_DRAIN, S_O_WRITE, S_DONE
    } state_t;

    state_t state, state_n;

    logic [RW-1:0] r;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic          act_q;

    logic signed [AW-1:0]    acc;
    logic signed [WIDTH-1:0] hid [H];

    logic [A_depth_bits-1:0]   a_addr_q;
    logic [B_depth_bits-1:0]   b_addr_q;
    logic [C_depth_bits-1:0]   c_addr_q;
    logic [RES_depth_bits-1:0] w_addr_q;
    logic [WIDTH-1:0]          w_data_q;

    logic k_last_n, k_last_h, j_last, r_last;
    assign k_last_n = (k == KW'(N - 1));
    assign k_last_h = (k == KW'(H - 1));
    assign j_last   = (j == JW'(H - 1));
    assign r_last   = (r == RW'(M - 1));

    // Datapath: one shared multiplier, operands switch to hidden*C in output phase
    logic                      out_ph;
    logic [KW-1:0]             hix;
    logic signed [WIDTH-1:0]   hv, op_a, op_b, bsrc;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      prod_x, bias_x, sh;
    logic                      sat_hi, sat_lo, clamp;
    logic signed [WIDTH-1:0]   res, hid_val;

    always_comb begin
        out_ph = (state == S_O_MAC) || (state == S_O_DRAIN);
        // product arriving now belongs to the hidden value issued last cycle
        hix = (state == S_O_DRAIN) ? KW'(H - 1) : k - KW'(1);
        hv = '0;
        for (int i = 0; i < H; i++)
            if (hix == KW'(i)) hv = hid[i];
        op_a   = out_ph ? hv : $signed(A_read_data_out);
        op_b   = out_ph ? $signed(C_read_data_out) : $signed(B_read_data_out);
        bsrc   = out_ph ? $signed(C_read_data_out) : $signed(B_read_data_out);
        prod   = op_a * op_b;
        prod_x = {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        bias_x = {{(AW-WIDTH){bsrc[WIDTH-1]}}, bsrc} <<< FRAC_BITS;
        sh     = acc >>> FRAC_BITS;
        sat_hi = (sh > MAXV);
        sat_lo = (sh < MINV);
        clamp  = sat_hi | sat_lo;
        if (sat_hi)      res = MAXV[WIDTH-1:0];
        else if (sat_lo) res = MINV[WIDTH-1:0];
        else             res = sh[WIDTH-1:0];
        hid_val = (act_q && res[WIDTH-1]) ? '0 : res;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (Start) state_n = S_H_BIAS;
            S_H_BIAS:  state_n = S_H_MAC;
            S_H_MAC:   if (k_last_n) state_n = S_H_DRAIN;
            S_H_DRAIN: state_n = S_H_ACT;
            S_H_ACT:   state_n = j_last ? S_O_BIAS : S_H_BIAS;
            S_O_BIAS:  state_n = S_O_MAC;
            S_O_MAC:   if (k_last_h) state_n = S_O_DRAIN;
            S_O_DRAIN: state_n = S_O_WRITE;
            S_O_WRITE: state_n = r_last ? S_DONE : S_H_BIAS;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // RAM ports: addresses fall back to the held copy whenever no access is issued
    always_comb begin
        Busy              = (state != S_IDLE) && (state != S_DONE);
        Done              = (state == S_DONE);
        A_read_en         = 1'b0;
        B_read_en         = 1'b0;
        C_read_en         = 1'b0;
        RES_write_en      = 1'b0;
        A_read_address    = a_addr_q;
        B_read_address    = b_addr_q;
        C_read_address    = c_addr_q;
        RES_write_address = w_addr_q;
        RES_write_data_in = w_data_q;
        unique case (state)
            S_H_BIAS: begin
                B_read_en      = 1'b1;
                B_read_address = B_depth_bits'(int'(j));
            end
            S_H_MAC: begin
                A_read_en      = 1'b1;
                A_read_address = A_depth_bits'(int'(r) * N + int'(k));
                B_read_en      = 1'b1;
                B_read_address = B_depth_bits'((int'(k) + 1) * H + int'(j));
            end
            S_O_BIAS: begin
                C_read_en      = 1'b1;
                C_read_address = '0;
            end
            S_O_MAC: begin
                C_read_en      = 1'b1;
                C_read_address = C_depth_bits'(int'(k) + 1);
            end
            S_O_WRITE: begin
                RES_write_en      = 1'b1;
                RES_write_address = RES_depth_bits'(int'(r));
                RES_write_data_in = res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r        <= '0;
            j        <= '0;
            k        <= '0;
            act_q    <= 1'b0;
            sat_flag <= 1'b0;
            acc      <= '0;
            for (int i = 0; i < H; i++) hid[i] <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            a_addr_q <= A_read_address;
            b_addr_q <= B_read_address;
            c_addr_q <= C_read_address;
            w_addr_q <= RES_write_address;
            w_data_q <= RES_write_data_in;
            unique case (state)
                S_IDLE: if (Start) begin
                    r        <= '0;
                    j        <= '0;
                    k        <= '0;
                    act_q    <= act_sel;
                    sat_flag <= 1'b0;
                end
                S_H_BIAS, S_O_BIAS: k <= '0;
                S_H_MAC: begin
                    acc <= (k == '0) ? bias_x : acc + prod_x;
                    if (!k_last_n) k <= k + KW'(1);
                end
                S_O_MAC: begin
                    acc <= (k == '0) ? bias_x : acc + prod_x;
                    if (!k_last_h) k <= k + KW'(1);
                end
                S_H_DRAIN, S_O_DRAIN: acc <= acc + prod_x;
                S_H_ACT: begin
                    for (int i = 0; i < H; i++)
                        if (j == JW'(i)) hid[i] <= hid_val;
                    if (clamp) sat_flag <= 1'b1;
                    if (!j_last) j <= j + JW'(1);
                end
                S_O_WRITE: begin
                    if (clamp) sat_flag <= 1'b1;
                    if (!r_last) r <= r + RW'(1);
                    j <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_infer_engine.sv
// Directed bench for mlp_infer_engine: small 2x2x2 instance for timing/corner
// cases, default 64x7x2 instance against a behavioural reference.
module tb_mlp_infer_engine;

    logic clk;
    logic aresetn;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- small instance (M=2, N=2, H=2) ----------------
    logic       s_start, s_act, s_busy, s_done, s_sat;
    logic       s_a_en, s_b_en, s_c_en, s_we;
    logic [8:0] s_a_addr;
    logic [3:0] s_b_addr;
    logic [1:0] s_c_addr;
    logic [5:0] s_w_addr;
    logic [7:0] s_a_do, s_b_do, s_c_do, s_w_data;
    logic [7:0] sa [0:511];
    logic [7:0] sb [0:15];
    logic [7:0] sc [0:3];
    logic [7:0] sres [0:63];
    int         wlog [$];
    int         s_done_cnt = 0;

    mlp_infer_engine #(.M(2), .N(2), .H(2)) u_s (
        .clk(clk), .aresetn(aresetn), .Start(s_start), .act_sel(s_act),
        .Busy(s_busy), .Done(s_done), .sat_flag(s_sat),
        .A_read_en(s_a_en), .A_read_address(s_a_addr), .A_read_data_out(s_a_do),
        .B_read_en(s_b_en), .B_read_address(s_b_addr), .B_read_data_out(s_b_do),
        .C_read_en(s_c_en), .C_read_address(s_c_addr), .C_read_data_out(s_c_do),
        .RES_write_en(s_we), .RES_write_address(s_w_addr),
        .RES_write_data_in(s_w_data)
    );

    always @(posedge clk) begin
        if (s_a_en) s_a_do <= sa[s_a_addr];
        if (s_b_en) s_b_do <= sb[s_b_addr];
        if (s_c_en) s_c_do <= sc[s_c_addr];
    end

    always @(negedge clk) begin
        if (s_we) begin
            sres[s_w_addr] <= s_w_data;
            wlog.push_back(int'(s_w_addr));
        end
        if (s_done) s_done_cnt++;
    end

    // ---------------- default instance (64x7x2) ----------------
    logic       b_start, b_act, b_busy, b_done, b_sat;
    logic       b_a_en, b_b_en, b_c_en, b_we;
    logic [8:0] b_a_addr;
    logic [3:0] b_b_addr;
    logic [1:0] b_c_addr;
    logic [5:0] b_w_addr;
    logic [7:0] b_a_do, b_b_do, b_c_do, b_w_data;
    logic [7:0] ba [0:511];
    logic [7:0] bb [0:15];
    logic [7:0] bc [0:3];
    logic [7:0] bres [0:63];
    logic [7:0] bexp [0:63];

    mlp_infer_engine u_b (
        .clk(clk), .aresetn(aresetn), .Start(b_start), .act_sel(b_act),
        .Busy(b_busy), .Done(b_done), .sat_flag(b_sat),
        .A_read_en(b_a_en), .A_read_address(b_a_addr), .A_read_data_out(b_a_do),
        .B_read_en(b_b_en), .B_read_address(b_b_addr), .B_read_data_out(b_b_do),
        .C_read_en(b_c_en), .C_read_address(b_c_addr), .C_read_data_out(b_c_do),
        .RES_write_en(b_we), .RES_write_address(b_w_addr),
        .RES_write_data_in(b_w_data)
    );

    always @(posedge clk) begin
        if (b_a_en) b_a_do <= ba[b_a_addr];
        if (b_b_en) b_b_do <= bb[b_b_addr];
        if (b_c_en) b_c_do <= bc[b_c_addr];
    end

    always @(negedge clk) if (b_we) bres[b_w_addr] <= b_w_data;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic sload(input logic [7:0] av, input logic [7:0] bw,
                         input logic [7:0] bbias, input logic [7:0] cw,
                         input logic [7:0] cbias);
        for (int i = 0; i < 4; i++) sa[i] = av;
        sb[0] = bbias;
        sb[1] = bbias;
        for (int i = 2; i < 6; i++) sb[i] = bw;
        sc[0] = cbias;
        sc[1] = cw;
        sc[2] = cw;
    endtask

    // Start on edge E0, then count cycles (n-th negedge after E0 = cycle n)
    task automatic srun(input logic act, input bit perturb, output int dcyc);
        dcyc = 0;
        @(negedge clk);
        s_act   = act;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("busy_c1", s_busy, 1);
        chk("b_en_c1", s_b_en, 1);
        chk("sat_clr_c1", s_sat, 0);
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            if (perturb) begin
                s_start = (n == 5 || n == 20 || n == 31);
                s_act   = ~act;
            end
            if (s_done) begin
                dcyc = n;
                break;
            end
        end
        @(negedge clk);
        s_start = 1'b0;
        s_act   = act;
    endtask

    function automatic logic [7:0] sat8(input longint v);
        longint s;
        s = v >>> 6;
        if (s > 127)  return 8'h7f;
        if (s < -128) return 8'h80;
        return s[7:0];
    endfunction

    // ---------------- stimulus ----------------
    int d, dc0;
    initial begin
        aresetn = 1'b0;
        s_start = 1'b0;
        s_act   = 1'b0;
        b_start = 1'b0;
        b_act   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        chk("rst_sat", s_sat, 0);
        chk("rst_ens", {s_a_en, s_b_en, s_c_en, s_we}, 0);
        chk("rst_addr", {s_a_addr, s_b_addr, s_c_addr, s_w_addr}, 0);
        chk("rst_wdata", s_w_data, 0);
        aresetn = 1'b1;

        // identity, all positive
        sload(8'h20, 8'h20, 8'h00, 8'h40, 8'h00);
        wlog.delete();
        dc0 = s_done_cnt;
        srun(1'b0, 1'b0, d);
        chk("t1_done_cyc", d, 31);
        chk("t1_done_pulse", s_done, 0);
        chk("t1_busy_end", s_busy, 0);
        repeat (2) @(negedge clk);
        chk("t1_res0", sres[0], 8'h40);
        chk("t1_res1", sres[1], 8'h40);
        chk("t1_sat", s_sat, 0);
        chk("t1_nwr", wlog.size(), 2);
        chk("t1_ndone", s_done_cnt - dc0, 1);

        // negative hidden: identity vs ReLU
        sload(8'h20, 8'he0, 8'h00, 8'h40, 8'h10);
        srun(1'b0, 1'b0, d);
        repeat (2) @(negedge clk);
        chk("t2_id_res0", sres[0], 8'hd0);
        chk("t2_id_res1", sres[1], 8'hd0);
        srun(1'b1, 1'b0, d);
        repeat (2) @(negedge clk);
        chk("t2_relu_res0", sres[0], 8'h10);
        chk("t2_relu_res1", sres[1], 8'h10);
        chk("t2_relu_sat", s_sat, 0);

        // saturation, sticky flag
        sload(8'h40, 8'h40, 8'h00, 8'h40, 8'h00);
        srun(1'b0, 1'b0, d);
        chk("t3_sat_done", s_sat, 1);
        repeat (4) @(negedge clk);
        chk("t3_sat_hold", s_sat, 1);
        chk("t3_res0", sres[0], 8'h7f);
        chk("t3_res1", sres[1], 8'h7f);

        // Start/act_sel noise while busy and on Done (next srun checks sat clear)
        sload(8'h20, 8'he0, 8'h00, 8'h40, 8'h10);
        wlog.delete();
        dc0 = s_done_cnt;
        srun(1'b0, 1'b1, d);
        chk("t4_done_cyc", d, 31);
        chk("t4_no_restart", s_busy, 0);
        chk("t4_no_read", s_b_en, 0);
        repeat (3) @(negedge clk);
        chk("t4_ndone", s_done_cnt - dc0, 1);
        chk("t4_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t4_wa0", wlog[0], 0);
            chk("t4_wa1", wlog[1], 1);
        end
        chk("t4_res0", sres[0], 8'hd0);
        chk("t4_res1", sres[1], 8'hd0);

        // reset mid-run at cycle 12
        sload(8'h20, 8'h20, 8'h00, 8'h40, 8'h00);
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (11) @(negedge clk);
        chk("t5_busy_pre", s_busy, 1);
        aresetn = 1'b0;
        #1;
        chk("t5_busy", s_busy, 0);
        chk("t5_ens", {s_a_en, s_b_en, s_c_en, s_we}, 0);
        chk("t5_addr", {s_a_addr, s_b_addr, s_c_addr, s_w_addr}, 0);
        chk("t5_sat", s_sat, 0);
        wlog.delete();
        dc0 = s_done_cnt;
        repeat (4) @(negedge clk);
        chk("t5_nwr", wlog.size(), 0);
        chk("t5_ndone", s_done_cnt - dc0, 0);
        aresetn = 1'b1;
        sload(8'h20, 8'he0, 8'h00, 8'h40, 8'h10);
        srun(1'b1, 1'b0, d);
        chk("t5_done_cyc", d, 31);
        repeat (2) @(negedge clk);
        chk("t5_res0", sres[0], 8'h10);
        chk("t5_res1", sres[1], 8'h10);

        // default geometry vs reference
        for (int i = 0; i < 448; i++) ba[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++)  bb[i] = 8'($urandom_range(0, 63) - 32);
        for (int i = 0; i < 3; i++)   bc[i] = 8'($urandom_range(0, 63) - 32);
        for (int r = 0; r < 64; r++) begin
            logic [7:0] hvv [2];
            longint acc;
            byte x, y;
            for (int jj = 0; jj < 2; jj++) begin
                x = bb[jj];
                acc = longint'(x) * 64;
                for (int kk = 0; kk < 7; kk++) begin
                    x = ba[r*7+kk];
                    y = bb[(kk+1)*2+jj];
                    acc += longint'(x) * longint'(y);
                end
                hvv[jj] = sat8(acc);
                if (hvv[jj][7]) hvv[jj] = 8'h00;
            end
            x = bc[0];
            acc = longint'(x) * 64;
            for (int jj = 0; jj < 2; jj++) begin
                x = hvv[jj];
                y = bc[jj+1];
                acc += longint'(x) * longint'(y);
            end
            bexp[r] = sat8(acc);
        end
        @(negedge clk);
        b_act   = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        d = 0;
        for (int n = 1; n <= 1700; n++) begin
            if (n > 1) @(negedge clk);
            if (b_done) begin
                d = n;
                break;
            end
        end
        chk("big_done_cyc", d, 1601);
        repeat (2) @(negedge clk);
        for (int r = 0; r < 64; r++)
            chk($sformatf("big_res%0d", r), bres[r], bexp[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
